// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and mstatus helpers for the
// machine-mode trap sequencer.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_MTIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEXT   = 32'h8000_000B;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;
    localparam int MIE_MEIE       = 11;

    localparam logic [31:0] MTVEC_MODE_MASK = 32'h0000_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEPC,
        S_MCAUSE,
        S_MSTATUS,
        S_MRET,
        S_ASSERT
    } state_e;

    // Trap entry: stash MIE in MPIE, mask interrupts, record M-mode.
    function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MPIE] = m[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[MSTATUS_MIE] = m[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects traps/mret in EX, writes the
// trap CSRs one per cycle, then pulses a redirect to the pipeline.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mie_i,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        stallreq_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    state_e      state_q;
    state_e      state_d;
    logic [31:0] epc_q;
    logic [31:0] cause_q;
    logic [31:0] target_q;

    logic        any_ex_flag;
    logic        tmr_req;
    logic        ext_req;
    logic        hit_ecall;
    logic        hit_ebreak;
    logic        hit_mret;
    logic        hit_tmr;
    logic        hit_ext;
    logic        trap_take;
    logic        mret_take;
    logic [31:0] cause_d;
    logic [31:0] epc_d;
    logic [31:0] irq_epc;
    logic        busy;
    logic        unused_mie;

    assign unused_mie = ^{csr_mie_i[31:12], csr_mie_i[10:8], csr_mie_i[6:0]};

    assign any_ex_flag = ecall_i | ebreak_i | mret_i;
    assign tmr_req = csr_mstatus_i[MSTATUS_MIE] & irq_timer_i
                   & csr_mie_i[MIE_MTIE];
    assign ext_req = csr_mstatus_i[MSTATUS_MIE] & irq_ext_i
                   & csr_mie_i[MIE_MEIE];

    // Mutually exclusive hit lines encode the detection priority.
    assign hit_ecall  = inst_valid_i & ecall_i;
    assign hit_ebreak = inst_valid_i & ebreak_i & ~ecall_i;
    assign hit_mret   = inst_valid_i & mret_i & ~ecall_i & ~ebreak_i;
    assign hit_tmr    = inst_valid_i & ~any_ex_flag & tmr_req;
    assign hit_ext    = inst_valid_i & ~any_ex_flag & ~tmr_req & ext_req;

    // An interrupt resumes at the branch target if EX resolved one.
    assign irq_epc = jump_flag_i ? jump_addr_i : inst_addr_i;

    always_comb begin
        trap_take = 1'b0;
        mret_take = 1'b0;
        cause_d   = '0;
        epc_d     = inst_addr_i;
        unique case (1'b1)
            hit_ecall: begin
                trap_take = 1'b1;
                cause_d   = CAUSE_ECALL;
            end
            hit_ebreak: begin
                trap_take = 1'b1;
                cause_d   = CAUSE_EBREAK;
            end
            hit_mret: begin
                mret_take = 1'b1;
            end
            hit_tmr: begin
                trap_take = 1'b1;
                cause_d   = CAUSE_MTIMER;
                epc_d     = irq_epc;
            end
            hit_ext: begin
                trap_take = 1'b1;
                cause_d   = CAUSE_MEXT;
                epc_d     = irq_epc;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (trap_take) begin
                    state_d = S_MEPC;
                end else if (mret_take) begin
                    state_d = S_MRET;
                end
            end
            S_MEPC:    state_d = S_MCAUSE;
            S_MCAUSE:  state_d = S_MSTATUS;
            S_MSTATUS: state_d = S_ASSERT;
            S_MRET:    state_d = S_ASSERT;
            S_ASSERT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        unique case (state_q)
            S_MEPC: begin
                busy        = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MEPC;
                csr_wdata_o = epc_q;
            end
            S_MCAUSE: begin
                busy        = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            S_MSTATUS: begin
                busy        = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = trap_mstatus(csr_mstatus_i);
            end
            S_MRET: begin
                busy        = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = CSR_MSTATUS;
                csr_wdata_o = mret_mstatus(csr_mstatus_i);
            end
            S_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = target_q;
            end
            default: ;
        endcase
    end

    // The detect-cycle stall is combinational; reset forces it low too.
    assign stallreq_o = rst_n & (busy | ((state_q == S_IDLE)
                      & (trap_take | mret_take)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && trap_take) begin
                epc_q   <= epc_d;
                cause_q <= cause_d;
            end
            if (state_q == S_MSTATUS) begin
                target_q <= csr_mtvec_i & ~MTVEC_MODE_MASK;
            end else if (state_q == S_MRET) begin
                target_q <= csr_mepc_i;
            end
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed table, hand sequences
// and a randomized run against a transaction-level reference model.
module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        inst_valid_i;
    logic [31:0] inst_addr_i;
    logic        ecall_i;
    logic        ebreak_i;
    logic        mret_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        irq_timer_i;
    logic        irq_ext_i;
    logic [31:0] csr_mtvec_i;
    logic [31:0] csr_mepc_i;
    logic [31:0] csr_mstatus_i;
    logic [31:0] csr_mie_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        stallreq_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    // Bench-side CSR file, updated from the DUT write port.
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mstatus;
    logic [31:0] m_mtvec;
    logic [31:0] m_mie;

    assign csr_mepc_i    = m_mepc;
    assign csr_mstatus_i = m_mstatus;
    assign csr_mtvec_i   = m_mtvec;
    assign csr_mie_i     = m_mie;

    trap_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid_i (inst_valid_i),
        .inst_addr_i  (inst_addr_i),
        .ecall_i      (ecall_i),
        .ebreak_i     (ebreak_i),
        .mret_i       (mret_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .irq_timer_i  (irq_timer_i),
        .irq_ext_i    (irq_ext_i),
        .csr_mtvec_i  (csr_mtvec_i),
        .csr_mepc_i   (csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i),
        .csr_mie_i    (csr_mie_i),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .stallreq_o   (stallreq_o),
        .int_assert_o (int_assert_o),
        .int_addr_o   (int_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        ia;
        logic [31:0] iaddr;
    } obs_t;

    typedef struct {
        logic        valid;
        logic        ecall;
        logic        ebreak;
        logic        mret;
        logic        tmr;
        logic        ext;
        logic        jf;
        logic [31:0] pc;
        logic [31:0] jaddr;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic        exp_stall;
        int          exp_n;
        logic [31:0] exp_cause;
        logic [31:0] exp_mepc;
    } vec_t;

    localparam logic [31:0] SENT_CAUSE = 32'hDEAD_BEEF;
    localparam logic [31:0] SENT_EPC   = 32'h0000_0444;

    int n_pass;
    int n_total;

    function automatic obs_t mk(input logic s, input logic w,
                                input logic [11:0] a, input logic [31:0] d,
                                input logic i, input logic [31:0] t);
        obs_t o;
        o = {s, w, a, d, i, t};
        return o;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o = {stallreq_o, csr_we_o, csr_waddr_o, csr_wdata_o,
             int_assert_o, int_addr_o};
        return o;
    endfunction

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Commit this cycle's CSR write into the bench CSR file, then step.
    task automatic adv();
        if (csr_we_o === 1'b1) begin
            case (csr_waddr_o)
                12'h341: m_mepc = csr_wdata_o;
                12'h342: m_mcause = csr_wdata_o;
                12'h300: m_mstatus = csr_wdata_o;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        inst_valid_i = 1'b0;
        inst_addr_i  = '0;
        ecall_i      = 1'b0;
        ebreak_i     = 1'b0;
        mret_i       = 1'b0;
        jump_flag_i  = 1'b0;
        jump_addr_i  = '0;
        irq_timer_i  = 1'b0;
        irq_ext_i    = 1'b0;
    endtask

    // Counts stall cycles after the detect cycle up to the redirect.
    task automatic finish_seq(output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (int_assert_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
            n++;
            adv();
        end
        if (seen) begin
            adv();
        end else begin
            n = -1;
        end
    endtask

    function automatic logic [31:0] ref_trap_ms(input logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] ref_mret_ms(input logic [31:0] m);
        return (m & ~32'h0000_0088) | 32'h80 | (m[7] ? 32'h8 : 32'h0);
    endfunction

    vec_t vecs[13];
    obs_t q[$];

    initial begin
        int n;
        obs_t e;
        n_pass  = 0;
        n_total = 0;
        m_mepc    = '0;
        m_mcause  = '0;
        m_mstatus = '0;
        m_mtvec   = 32'h8000_0101;
        m_mie     = '0;
        clear_in();

        // Reset state, with a trap-looking EX instruction held in reset.
        rst_n = 1'b0;
        inst_valid_i = 1'b1;
        ecall_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", cur(), mk(0, 0, 12'h0, 0, 0, 0));
        clear_in();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", cur(), mk(0, 0, 12'h0, 0, 0, 0));
        adv();

        // ecall at 0x80000010, mtvec 0x80000101, cycle by cycle.
        m_mstatus = 32'h8;
        inst_valid_i = 1'b1;
        inst_addr_i = 32'h8000_0010;
        ecall_i = 1'b1;
        @(negedge clk);
        check("ecall_t0", cur(), mk(1, 0, 12'h0, 0, 0, 0));
        adv();
        clear_in();
        @(negedge clk);
        check("ecall_t1", cur(), mk(1, 1, 12'h341, 32'h8000_0010, 0, 0));
        adv();
        @(negedge clk);
        check("ecall_t2", cur(), mk(1, 1, 12'h342, 32'd11, 0, 0));
        adv();
        @(negedge clk);
        check("ecall_t3", cur(), mk(1, 1, 12'h300, 32'h0000_1880, 0, 0));
        adv();
        @(negedge clk);
        check("ecall_t4", cur(), mk(0, 0, 12'h0, 0, 1, 32'h8000_0100));
        adv();
        @(negedge clk);
        check("ecall_t5", cur(), mk(0, 0, 12'h0, 0, 0, 0));
        adv();

        // mret with mepc 0x80000014 and MPIE set.
        m_mepc = 32'h8000_0014;
        m_mstatus = 32'h80;
        inst_valid_i = 1'b1;
        mret_i = 1'b1;
        @(negedge clk);
        check("mret_t0", cur(), mk(1, 0, 12'h0, 0, 0, 0));
        adv();
        clear_in();
        @(negedge clk);
        check("mret_t1", cur(), mk(1, 1, 12'h300, 32'h88, 0, 0));
        adv();
        @(negedge clk);
        check("mret_t2", cur(), mk(0, 0, 12'h0, 0, 1, 32'h8000_0014));
        adv();

        // Directed detection table.
        vecs[0]  = '{1,1,0,0,0,0,0, 32'h100, 0, 32'h8, 32'h0,   1, 3, 32'd11, 32'h100};
        vecs[1]  = '{1,0,1,0,0,0,0, 32'h104, 0, 32'h8, 32'h0,   1, 3, 32'd3, 32'h104};
        vecs[2]  = '{1,1,1,0,0,0,0, 32'h108, 0, 32'h0, 32'h0,   1, 3, 32'd11, 32'h108};
        vecs[3]  = '{1,0,1,1,0,0,0, 32'h10c, 0, 32'h0, 32'h0,   1, 3, 32'd3, 32'h10c};
        vecs[4]  = '{1,0,0,1,1,1,0, 32'h110, 0, 32'h8, 32'h880, 1, 1, SENT_CAUSE, SENT_EPC};
        vecs[5]  = '{1,0,0,0,1,0,1, 32'h114, 32'h200, 32'h8, 32'h80, 1, 3, 32'h8000_0007, 32'h200};
        vecs[6]  = '{1,0,0,0,0,1,0, 32'h118, 0, 32'h8, 32'h800, 1, 3, 32'h8000_000B, 32'h118};
        vecs[7]  = '{1,0,0,0,1,1,1, 32'h11c, 32'h300, 32'h8, 32'h880, 1, 3, 32'h8000_0007, 32'h300};
        vecs[8]  = '{1,0,0,0,1,1,0, 32'h120, 0, 32'h8, 32'h800, 1, 3, 32'h8000_000B, 32'h120};
        vecs[9]  = '{1,0,0,0,1,0,0, 32'h124, 0, 32'h0, 32'h880, 0, -1, SENT_CAUSE, SENT_EPC};
        vecs[10] = '{0,1,0,0,1,1,0, 32'h128, 0, 32'h8, 32'h880, 0, -1, SENT_CAUSE, SENT_EPC};
        vecs[11] = '{1,1,0,0,1,1,0, 32'h12c, 0, 32'h8, 32'h880, 1, 3, 32'd11, 32'h12c};
        vecs[12] = '{1,0,0,0,0,1,0, 32'h130, 0, 32'h8, 32'h080, 0, -1, SENT_CAUSE, SENT_EPC};
        for (int i = 0; i < 13; i++) begin
            m_mstatus = vecs[i].mstatus;
            m_mie = vecs[i].mie;
            m_mcause = SENT_CAUSE;
            m_mepc = SENT_EPC;
            inst_valid_i = vecs[i].valid;
            ecall_i = vecs[i].ecall;
            ebreak_i = vecs[i].ebreak;
            mret_i = vecs[i].mret;
            irq_timer_i = vecs[i].tmr;
            irq_ext_i = vecs[i].ext;
            jump_flag_i = vecs[i].jf;
            jump_addr_i = vecs[i].jaddr;
            inst_addr_i = vecs[i].pc;
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), 96'(stallreq_o),
                  96'(vecs[i].exp_stall));
            adv();
            clear_in();
            finish_seq(n);
            check($sformatf("vec%0d_len", i), 96'(n), 96'(vecs[i].exp_n));
            check($sformatf("vec%0d_mcause", i), 96'(m_mcause),
                  96'(vecs[i].exp_cause));
            check($sformatf("vec%0d_mepc", i), 96'(m_mepc),
                  96'(vecs[i].exp_mepc));
        end

        // Timer branch case, then the same setup with MIE cleared.
        m_mstatus = 32'h8;
        m_mie = 32'h80;
        inst_valid_i = 1'b1;
        inst_addr_i = 32'h8000_0300;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h8000_0200;
        irq_timer_i = 1'b1;
        @(negedge clk);
        check("tmr_t0", cur(), mk(1, 0, 12'h0, 0, 0, 0));
        adv();
        @(negedge clk);
        check("tmr_t1", cur(), mk(1, 1, 12'h341, 32'h8000_0200, 0, 0));
        adv();
        @(negedge clk);
        check("tmr_t2", cur(), mk(1, 1, 12'h342, 32'h8000_0007, 0, 0));
        adv();
        finish_seq(n);
        check("tmr_tail_len", 96'(n), 96'(1));
        m_mstatus = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("tmr_masked", cur(), mk(0, 0, 12'h0, 0, 0, 0));
            adv();
        end
        clear_in();

        // Both IRQs with ecall; mret then exposes timer, then external.
        m_mstatus = 32'h8;
        m_mie = 32'h880;
        m_mtvec = 32'h8000_0101;
        inst_valid_i = 1'b1;
        inst_addr_i = 32'h8000_0040;
        ecall_i = 1'b1;
        irq_timer_i = 1'b1;
        irq_ext_i = 1'b1;
        adv();
        ecall_i = 1'b0;
        inst_valid_i = 1'b0;
        finish_seq(n);
        check("combo_ecall_cause", 96'(m_mcause), 96'(32'd11));
        inst_valid_i = 1'b1;
        mret_i = 1'b1;
        adv();
        mret_i = 1'b0;
        finish_seq(n);
        check("combo_mret_len", 96'(n), 96'(1));
        check("combo_mie_back", 96'(m_mstatus[3]), 96'(1'b1));
        finish_seq(n);
        check("combo_tmr_cause", 96'(m_mcause), 96'(32'h8000_0007));
        irq_timer_i = 1'b0;
        mret_i = 1'b1;
        adv();
        mret_i = 1'b0;
        finish_seq(n);
        finish_seq(n);
        check("combo_ext_cause", 96'(m_mcause), 96'(32'h8000_000B));
        clear_in();
        adv();

        // Reset while in the mcause step.
        m_mstatus = 32'h8;
        m_mcause = SENT_CAUSE;
        inst_valid_i = 1'b1;
        inst_addr_i = 32'h8000_0050;
        ecall_i = 1'b1;
        adv();
        clear_in();
        adv();
        @(negedge clk);
        check("rst_mid_pre", 96'(csr_waddr_o), 96'(12'h342));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", cur(), mk(0, 0, 12'h0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("rst_mid_hold", cur(), mk(0, 0, 12'h0, 0, 0, 0));
        check("rst_no_mstatus", 96'(m_mstatus), 96'(32'h8));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_idle", cur(), mk(0, 0, 12'h0, 0, 0, 0));
        adv();
        inst_valid_i = 1'b1;
        inst_addr_i = 32'h8000_0060;
        ecall_i = 1'b1;
        adv();
        clear_in();
        finish_seq(n);
        check("rst_fresh_len", 96'(n), 96'(3));
        check("rst_fresh_mepc", 96'(m_mepc), 96'(32'h8000_0060));
        check("rst_fresh_mcause", 96'(m_mcause), 96'(32'd11));

        // Randomized run against a transaction-level model.
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (q.size() == 0) begin
                if ($urandom_range(0, 7) == 0) m_mstatus = $urandom;
                if ($urandom_range(0, 7) == 0) m_mie = $urandom;
                if ($urandom_range(0, 7) == 0) m_mtvec = $urandom;
                if ($urandom_range(0, 7) == 0) m_mepc = $urandom;
            end
            inst_valid_i = ($urandom_range(0, 3) != 0);
            inst_addr_i  = $urandom;
            ecall_i      = ($urandom_range(0, 19) == 0);
            ebreak_i     = ($urandom_range(0, 19) == 0);
            mret_i       = ($urandom_range(0, 11) == 0);
            jump_flag_i  = $urandom_range(0, 1) == 1;
            jump_addr_i  = $urandom;
            if ($urandom_range(0, 9) == 0) irq_timer_i = ~irq_timer_i;
            if ($urandom_range(0, 9) == 0) irq_ext_i = ~irq_ext_i;

            if (q.size() != 0) begin
                e = q.pop_front();
            end else begin
                logic        take;
                logic [31:0] cs;
                logic [31:0] ep;
                logic [31:0] irq_ep;
                irq_ep = jump_flag_i ? jump_addr_i : inst_addr_i;
                take = 1'b0;
                cs = '0;
                ep = '0;
                e = mk(0, 0, 12'h0, 0, 0, 0);
                if (inst_valid_i) begin
                    if (ecall_i) begin
                        take = 1'b1; cs = 32'd11; ep = inst_addr_i;
                    end else if (ebreak_i) begin
                        take = 1'b1; cs = 32'd3; ep = inst_addr_i;
                    end else if (mret_i) begin
                        e = mk(1, 0, 12'h0, 0, 0, 0);
                        q.push_back(mk(1, 1, 12'h300, ref_mret_ms(m_mstatus), 0, 0));
                        q.push_back(mk(0, 0, 12'h0, 0, 1, m_mepc));
                    end else if (m_mstatus[3] && irq_timer_i && m_mie[7]) begin
                        take = 1'b1; cs = 32'h8000_0007; ep = irq_ep;
                    end else if (m_mstatus[3] && irq_ext_i && m_mie[11]) begin
                        take = 1'b1; cs = 32'h8000_000B; ep = irq_ep;
                    end
                end
                if (take) begin
                    e = mk(1, 0, 12'h0, 0, 0, 0);
                    q.push_back(mk(1, 1, 12'h341, ep, 0, 0));
                    q.push_back(mk(1, 1, 12'h342, cs, 0, 0));
                    q.push_back(mk(1, 1, 12'h300, ref_trap_ms(m_mstatus), 0, 0));
                    q.push_back(mk(0, 0, 12'h0, 0, 1, m_mtvec & ~32'h3));
                end
            end
            @(negedge clk);
            check($sformatf("rand_c%0d", c), cur(), e);
            adv();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
